tl_arb_mux: RTL and testbench
=============================

TL_ARB_MUX -- requirements
Module: tl_arb_mux

Interface
REQ-001 SHALL have parameter N, default 4: number of source ports.
REQ-002 SHALL have parameter DATA_W, default 64: beat payload width.
REQ-003 SHALL have parameter SEL_W, default 2: width of the granted-port index; N <= 2**SEL_W.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port valid_i, input, N: per-source beat valid.
REQ-007 SHALL have port ready_o, output, N: per-source beat accept.
REQ-008 SHALL have port data_i, input, N*DATA_W: per-source payload; port i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port last_i, input, N: per-source final-beat-of-message flag.
REQ-010 SHALL have port valid_o, output, 1: merged beat valid to sink.
REQ-011 SHALL have port ready_i, input, 1: sink accept.
REQ-012 SHALL have port data_o, output, DATA_W: merged payload.
REQ-013 SHALL have port last_o, output, 1: merged last flag.
REQ-014 SHALL have port sel_o, output, SEL_W: index of the source owning the current beat, used for response routing.

Function
REQ-015 A transfer SHALL occur on any cycle with valid && ready on the same channel.
REQ-016 The state machine SHALL have states IDLE (no owner) and LOCKED (owner fixed).
REQ-017 In IDLE, grant SHALL go to the first i with valid_i[i]=1, searching from rr_ptr upward modulo N, decided combinationally in the same cycle.
REQ-018 In LOCKED, grant SHALL be the registered owner, regardless of other valid_i.
REQ-019 valid_o, data_o, last_o and sel_o SHALL reflect the granted port; valid_o=0 when no port is granted.
REQ-020 ready_o[g]=ready_i for granted port g; all other ready_o bits SHALL be 0.
REQ-021 IDLE->LOCKED SHALL occur when valid_o=1 and not (transfer with last_o=1), i.e. on a stalled beat or a non-final transfer; owner <= g.
REQ-022 LOCKED->IDLE SHALL occur on a transfer with last_o=1.
REQ-023 On every transfer with last_o=1, rr_ptr SHALL update to (g+1) mod N, wrapping from N-1 to 0 for non-power-of-2 N.
REQ-024 A single-beat message accepted in the same cycle it is granted SHALL leave the state in IDLE; the next message may be granted on the following cycle, giving 1 beat/cycle throughput.
REQ-025 Data SHALL pass combinationally with zero-cycle latency (macro absent).
REQ-026 Simultaneous requests from all N ports SHALL each be served once per N messages (fairness).

Reset
REQ-027 While rst_i=1 at a rising edge: state <= IDLE, rr_ptr <= 0, owner <= 0, and the macro buffer SHALL be emptied.
REQ-028 After reset, valid_o SHALL be 0 until a valid_i is seen, and ready_o SHALL be 0 while no grant exists.
REQ-029 Reset mid-message SHALL abandon the message with no further beat issued from the stale owner.

Configuration
REQ-030 Macro TL_ARB_MUX_OUT_REG_EN, when defined, SHALL insert a 2-entry skid buffer between the arbiter and {valid_o, data_o, last_o, sel_o}.
REQ-031 With the macro defined: 1-cycle latency; full throughput; outputs driven from registers; no combinational path from ready_i to ready_o.
REQ-032 With the macro defined, the arbiter's ready SHALL be "buffer not full", and lock and rr_ptr updates SHALL track the arbiter-side transfer.
REQ-033 Without the macro, the behaviour SHALL be as REQ-025.

Structure
REQ-034 A shared package tl_xbar_pkg SHALL hold the IDLE/LOCKED state encoding and the default N/DATA_W/SEL_W constants shared with the xbar demux.
REQ-035 The round-robin pick SHALL be sub-module tl_rr_arbiter: inputs req[N] and ptr; outputs one-hot gnt and index; combinational.

Verification
REQ-036 Reset check: rst_i=1 for 2 cycles with valid_i=4'b1111 -> valid_o=0, ready_o=0 during reset; first grant after release is port 0.
REQ-037 Round-robin: N=4, all ports send 1-beat messages with ready_i=1 -> sel_o sequence 0,1,2,3,0, one beat per cycle.
REQ-038 Lock: port 2 sends 4 beats (last on beat 4) while port 1 is valid -> sel_o=2 for all 4 beats, then sel_o=3 if port 3 is requesting, else 1.
REQ-039 Stall hold: port 1 is granted with ready_i=0 for 3 cycles and port 0 raises valid -> grant stays 1, data_o stable, ready_o=4'b0000 until ready_i=1.
REQ-040 N=3 wrap: grant port 2 then all request -> next grant is port 0; rr_ptr never equals 3.
REQ-041 Macro on: the same stimulus as REQ-037 -> identical sel_o sequence delayed 1 cycle; ready_i toggling 1010 loses no beats and duplicates none.

Source files
------------

// File: rtl/tl_xbar_pkg.sv
// Shared crossbar definitions: FSM state encoding, default geometry, round-robin helper.
// Used by the arbitrating mux and the response-side demux.
package tl_xbar_pkg;

  localparam int TL_N      = 4;
  localparam int TL_DATA_W = 64;
  localparam int TL_SEL_W  = 2;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Successor of idx in a ring of n ports; wraps explicitly for non-power-of-2 n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, modulo N.
// Zero latency; no flow control of its own.
module tl_rr_arbiter
  import tl_xbar_pkg::*;
#(
  parameter int N     = TL_N,
  parameter int SEL_W = TL_SEL_W
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] index
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    index = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        index  = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/tl_arb_mux.sv
// N:1 message-locked round-robin mux; zero latency, or a 2-entry output skid buffer
// (1-cycle latency, ready_o decoupled from ready_i) when TL_ARB_MUX_OUT_REG_EN is defined.
module tl_arb_mux
  import tl_xbar_pkg::*;
#(
  parameter int N      = TL_N,
  parameter int DATA_W = TL_DATA_W,
  parameter int SEL_W  = TL_SEL_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0]        valid_i,
  output logic [N-1:0]        ready_o,
  input  logic [N*DATA_W-1:0] data_i,
  input  logic [N-1:0]        last_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                last_o,
  output logic [SEL_W-1:0]    sel_o
);

  logic [0:0]        state;
  logic [SEL_W-1:0]  owner;
  logic [SEL_W-1:0]  rr_ptr;
  logic [N-1:0]      rr_gnt;
  logic [SEL_W-1:0]  rr_idx;

  logic              locked;
  logic              g_any;
  logic [SEL_W-1:0]  g_idx;
  logic              a_vld;
  logic              a_rdy;
  logic              a_last;
  logic [DATA_W-1:0] a_dat;
  logic              a_xfer;

  tl_rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_rr (
    .req   (valid_i),
    .ptr   (rr_ptr),
    .gnt   (rr_gnt),
    .index (rr_idx)
  );

  // Reset gates the grant so nothing leaks out of a stale owner while rst_i is high.
  always_comb begin
    locked  = (state == ST_LOCKED);
    g_idx   = locked ? owner : rr_idx;
    g_any   = !rst_i && (locked || (|rr_gnt));
    a_vld   = 1'b0;
    a_dat   = '0;
    a_last  = 1'b0;
    ready_o = '0;
    for (int i = 0; i < N; i++) begin
      if (g_idx == SEL_W'(i)) begin
        a_vld      = g_any && valid_i[i];
        a_dat      = data_i[i*DATA_W +: DATA_W];
        a_last     = last_i[i];
        ready_o[i] = g_any && a_rdy;
      end
    end
  end

  assign a_xfer = a_vld && a_rdy;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else if (a_xfer && a_last) begin
      state  <= ST_IDLE;
      rr_ptr <= SEL_W'(rr_next(int'(g_idx), N));
    end else if (a_vld) begin
      state  <= ST_LOCKED;
      owner  <= g_idx;
    end
  end

`ifdef TL_ARB_MUX_OUT_REG_EN
  logic [1:0]        cnt;
  logic [DATA_W-1:0] dat_q  [2];
  logic              last_q [2];
  logic [SEL_W-1:0]  sel_q  [2];
  logic              pop;
  logic              wr_head;

  assign a_rdy   = (cnt != 2'd2);
  assign pop     = valid_o && ready_i;
  // A push lands in the head slot when the buffer is, or is about to become, empty.
  assign wr_head = (cnt == 2'd0) || ((cnt == 2'd1) && pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= 2'd0;
    end else begin
      if (pop) begin
        dat_q[0]  <= dat_q[1];
        last_q[0] <= last_q[1];
        sel_q[0]  <= sel_q[1];
      end
      if (a_xfer) begin
        if (wr_head) begin
          dat_q[0]  <= a_dat;
          last_q[0] <= a_last;
          sel_q[0]  <= g_idx;
        end else begin
          dat_q[1]  <= a_dat;
          last_q[1] <= a_last;
          sel_q[1]  <= g_idx;
        end
      end
      cnt <= cnt + 2'(a_xfer) - 2'(pop);
    end
  end

  assign valid_o = !rst_i && (cnt != 2'd0);
  assign data_o  = dat_q[0];
  assign last_o  = last_q[0];
  assign sel_o   = sel_q[0];
`else
  assign a_rdy   = ready_i;
  assign valid_o = a_vld;
  assign data_o  = a_dat;
  assign last_o  = a_last;
  assign sel_o   = g_idx;
`endif

endmodule

// File: tb/tb_tl_arb_mux.sv
// Directed bench for tl_arb_mux: per-cycle vector table, N=3 wrap sequence, ordering under stalls.
module tb_tl_arb_mux;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int SW = 2;
  localparam int NV = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    valid, last, rdy_o;
  logic [N*DW-1:0] data;
  logic            vo, ri, lo;
  logic [DW-1:0]   dout;
  logic [SW-1:0]   so;

  logic            rst3;
  logic [2:0]      valid3, last3, rdy_o3;
  logic [3*DW-1:0] data3;
  logic            vo3, ri3, lo3;
  logic [DW-1:0]   dout3;
  logic [SW-1:0]   so3;

  int checks   = 0;
  int failures = 0;

  tl_arb_mux #(.N(N), .DATA_W(DW), .SEL_W(SW)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(rdy_o), .data_i(data),
    .last_i(last), .valid_o(vo), .ready_i(ri), .data_o(dout), .last_o(lo), .sel_o(so)
  );

  tl_arb_mux #(.N(3), .DATA_W(DW), .SEL_W(SW)) dut3 (
    .clk_i(clk), .rst_i(rst3), .valid_i(valid3), .ready_o(rdy_o3), .data_i(data3),
    .last_i(last3), .valid_o(vo3), .ready_i(ri3), .data_o(dout3), .last_o(lo3), .sel_o(so3)
  );

  typedef struct {
    logic       rs;
    logic [3:0] v;
    logic [3:0] l;
    logic       r;
    logic       ev;
    logic [3:0] er;
    logic [1:0] es;
    logic       el;
  } vec_t;

  vec_t tbl [NV];

  function automatic logic [15:0] pat(input int i);
    return 16'(32'h1000 * (i + 1) + i);
  endfunction

  function automatic vec_t mk(input logic rs, input logic [3:0] v, input logic [3:0] l,
                              input logic r, input logic ev, input logic [3:0] er,
                              input logic [1:0] es, input logic el);
    vec_t t;
    t.rs = rs; t.v = v; t.l = l; t.r = r; t.ev = ev; t.er = er; t.es = es; t.el = el;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_sel;
  int beats;

  initial begin
    // rst, valid, last, ready_i | valid_o, ready_o, sel_o, last_o
    tbl[0]  = mk(1, 4'b1111, 4'b1111, 1, 0, 4'b0000, 0, 0);
    tbl[1]  = mk(1, 4'b1111, 4'b1111, 1, 0, 4'b0000, 0, 0);
    tbl[2]  = mk(0, 4'b1111, 4'b1111, 1, 1, 4'b0001, 0, 1);
    tbl[3]  = mk(0, 4'b1111, 4'b1111, 1, 1, 4'b0010, 1, 1);
    tbl[4]  = mk(0, 4'b1111, 4'b1111, 1, 1, 4'b0100, 2, 1);
    tbl[5]  = mk(0, 4'b1111, 4'b1111, 1, 1, 4'b1000, 3, 1);
    tbl[6]  = mk(0, 4'b1111, 4'b1111, 1, 1, 4'b0001, 0, 1);
    tbl[7]  = mk(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0);
    tbl[8]  = mk(0, 4'b0010, 4'b0010, 1, 1, 4'b0010, 1, 1);
    tbl[9]  = mk(0, 4'b0110, 4'b0000, 1, 1, 4'b0100, 2, 0);
    tbl[10] = mk(0, 4'b0110, 4'b0000, 1, 1, 4'b0100, 2, 0);
    tbl[11] = mk(0, 4'b1110, 4'b0000, 1, 1, 4'b0100, 2, 0);
    tbl[12] = mk(0, 4'b1110, 4'b0100, 1, 1, 4'b0100, 2, 1);
    tbl[13] = mk(0, 4'b1010, 4'b1010, 1, 1, 4'b1000, 3, 1);
    tbl[14] = mk(0, 4'b0010, 4'b0010, 1, 1, 4'b0010, 1, 1);
    tbl[15] = mk(0, 4'b0010, 4'b0010, 0, 1, 4'b0000, 1, 1);
    tbl[16] = mk(0, 4'b0011, 4'b0011, 0, 1, 4'b0000, 1, 1);
    tbl[17] = mk(0, 4'b0011, 4'b0011, 0, 1, 4'b0000, 1, 1);
    tbl[18] = mk(0, 4'b0011, 4'b0011, 1, 1, 4'b0010, 1, 1);
    tbl[19] = mk(0, 4'b0001, 4'b0001, 1, 1, 4'b0001, 0, 1);
    tbl[20] = mk(0, 4'b0100, 4'b0000, 1, 1, 4'b0100, 2, 0);
    tbl[21] = mk(0, 4'b0001, 4'b0001, 1, 0, 4'b0100, 0, 0);
    tbl[22] = mk(0, 4'b0101, 4'b0100, 1, 1, 4'b0100, 2, 1);
    tbl[23] = mk(0, 4'b0001, 4'b0001, 1, 1, 4'b0001, 0, 1);
    tbl[24] = mk(0, 4'b1000, 4'b0000, 1, 1, 4'b1000, 3, 0);
    tbl[25] = mk(1, 4'b1000, 4'b0000, 1, 0, 4'b0000, 0, 0);
    tbl[26] = mk(0, 4'b1010, 4'b1010, 1, 1, 4'b0010, 1, 1);

    for (int i = 0; i < N; i++) data[i*DW +: DW] = pat(i);
    for (int i = 0; i < 3; i++) data3[i*DW +: DW] = pat(i);
    rst = 1'b1; valid = '0; last = '0; ri = 1'b0;
    rst3 = 1'b1; valid3 = '0; last3 = 3'b111; ri3 = 1'b1;
    tick();

`ifndef TL_ARB_MUX_OUT_REG_EN
    for (int k = 0; k < NV; k++) begin
      rst = tbl[k].rs; valid = tbl[k].v; last = tbl[k].l; ri = tbl[k].r;
      #2;
      chk("valid_o", k, 32'(vo), 32'(tbl[k].ev));
      chk("ready_o", k, 32'(rdy_o), 32'(tbl[k].er));
      if (tbl[k].ev) begin
        chk("sel_o", k, 32'(so), 32'(tbl[k].es));
        chk("data_o", k, 32'(dout), 32'(pat(int'(tbl[k].es))));
        chk("last_o", k, 32'(lo), 32'(tbl[k].el));
      end
      tick();
    end

    // N=3: after port 2 the pointer must wrap to 0, never to a nonexistent port 3.
    rst3 = 1'b0;
    begin
      logic [2:0] v3 [6];
      int         s3 [6];
      v3[0] = 3'b100; s3[0] = 2;
      v3[1] = 3'b111; s3[1] = 0;
      v3[2] = 3'b111; s3[2] = 1;
      v3[3] = 3'b111; s3[3] = 2;
      v3[4] = 3'b111; s3[4] = 0;
      v3[5] = 3'b011; s3[5] = 1;
      for (int k = 0; k < 6; k++) begin
        valid3 = v3[k];
        #2;
        chk("n3_valid_o", k, 32'(vo3), 32'd1);
        chk("n3_sel_o", k, 32'(so3), 32'(s3[k]));
        chk("n3_ready_o", k, 32'(rdy_o3), 32'(3'b001 << s3[k]));
        chk("n3_data_o", k, 32'(dout3), 32'(pat(s3[k])));
        tick();
      end
      valid3 = '0;
    end
`else
    // Registered output: same round-robin order, one cycle later.
    rst = 1'b1; valid = '0; ri = 1'b1;
    tick();
    rst = 1'b0; valid = 4'b1111; last = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #2;
      chk("lat_valid_o", k, 32'(vo), (k == 0) ? 32'd0 : 32'd1);
      if (k > 0) chk("lat_sel_o", k, 32'(so), 32'((k - 1) % 4));
      tick();
    end
`endif

    // Stall then ready_i toggling 1010: every accepted beat is the next port in ring order.
    rst = 1'b1; valid = '0; last = 4'b1111; ri = 1'b0;
    tick();
    rst = 1'b0; valid = 4'b1111;
    tick();
    tick();
    exp_sel = 0;
    beats   = 0;
    for (int c = 0; c < 8; c++) begin
      ri = (c % 2 == 0);
      #2;
      if (vo && ri) begin
        chk("order_sel", beats, 32'(so), 32'(exp_sel));
        chk("order_data", beats, 32'(dout), 32'(pat(exp_sel)));
        exp_sel = (exp_sel + 1) % N;
        beats++;
      end
      tick();
    end
    chk("order_beats", 0, 32'(beats), 32'd4);
    valid = '0;
    ri    = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
